// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester.
// Takes one command over a valid/ready port, runs an APB SETUP/ACCESS
// transfer, and returns the completion over a valid/ready response port.
// A programmable timeout aborts transfers to a slave that never raises pready.
module apb_master #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            pclk,
  input  logic            preset,
  // command port
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic            i_cmd_write,
  input  logic [AW-1:0]   i_cmd_addr,
  input  logic [DW-1:0]   i_cmd_wdata,
  input  logic [DW/8-1:0] i_cmd_strb,
  // response port
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [DW-1:0]   o_rsp_rdata,
  output logic            o_rsp_err,
  output logic            o_rsp_timeout,
  // APB request
  output logic [AW-1:0]   o_paddr,
  output logic            o_pwrite,
  output logic            o_psel,
  output logic            o_penable,
  output logic [DW-1:0]   o_pwdata,
  output logic [DW/8-1:0] o_pstrb,
  // APB completion
  input  logic [DW-1:0]   i_prdata,
  input  logic            i_pready,
  input  logic            i_pslverr
);

  localparam int unsigned SW      = DW / 8;
  // Counter is at least one bit wide so TIMEOUT = 0 still elaborates.
  localparam int unsigned TW      = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam bit          TO_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_cmd_ready;
  logic            r_psel;
  logic            r_penable;
  logic            r_rsp_valid;
  logic [AW-1:0]   r_paddr;
  logic            r_pwrite;
  logic [DW-1:0]   r_pwdata;
  logic [SW-1:0]   r_pstrb;
  logic [DW-1:0]   r_rsp_rdata;
  logic            r_rsp_err;
  logic            r_rsp_timeout;
  logic [TW-1:0]   r_to_cnt;

  logic            w_accept;
  logic            w_expire;
  logic            w_enter_resp;

  assign o_cmd_ready   = r_cmd_ready;
  assign o_psel        = r_psel;
  assign o_penable     = r_penable;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_paddr       = r_paddr;
  assign o_pwrite      = r_pwrite;
  assign o_pwdata      = r_pwdata;
  assign o_pstrb       = r_pstrb;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_err     = r_rsp_err;
  assign o_rsp_timeout = r_rsp_timeout;

  // Next-state logic; the expiry fires on the last allowed low-pready ACCESS cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = r_cmd_ready & i_cmd_valid;
    w_expire     = TO_EN && !i_pready && (r_to_cnt >= TW'(TO_LAST));
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_SETUP;
      end
      S_SETUP: begin
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (i_pready || w_expire) begin
          w_state_nxt  = S_RESP;
          w_enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and handshake/strobe outputs, registered from the next state.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_psel      <= (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
      r_penable   <= (w_state_nxt == S_ACCESS);
      r_rsp_valid <= (w_state_nxt == S_RESP);
    end
  end

  // Request capture on command acceptance; read strobes are forced to zero.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_pstrb  <= '0;
    end else if (w_accept) begin
      r_paddr  <= i_cmd_addr;
      r_pwrite <= i_cmd_write;
      r_pwdata <= i_cmd_wdata;
      r_pstrb  <= i_cmd_write ? i_cmd_strb : SW'(0);
    end
  end

  // Saturating count of low-pready ACCESS cycles, cleared on entry to SETUP.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_to_cnt <= '0;
    end else if (w_state_nxt == S_SETUP) begin
      r_to_cnt <= '0;
    end else if ((r_state == S_ACCESS) && !i_pready && (r_to_cnt < TW'(TIMEOUT))) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  // Response fields change only on the transition into RESP; pready beats expiry.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else if (w_enter_resp) begin
      if (i_pready) begin
        r_rsp_rdata   <= r_pwrite ? DW'(0) : i_prdata;
        r_rsp_err     <= i_pslverr;
        r_rsp_timeout <= 1'b0;
      end else begin
        r_rsp_rdata   <= '0;
        r_rsp_err     <= 1'b1;
        r_rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master (DW=32, AW=5, TIMEOUT=4).
module tb_apb_master;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned SW = DW / 8;

  logic          pclk;
  logic          preset;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic          i_cmd_write;
  logic [AW-1:0] i_cmd_addr;
  logic [DW-1:0] i_cmd_wdata;
  logic [SW-1:0] i_cmd_strb;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [DW-1:0] o_rsp_rdata;
  logic          o_rsp_err;
  logic          o_rsp_timeout;
  logic [AW-1:0] o_paddr;
  logic          o_pwrite;
  logic          o_psel;
  logic          o_penable;
  logic [DW-1:0] o_pwdata;
  logic [SW-1:0] o_pstrb;
  logic [DW-1:0] i_prdata;
  logic          i_pready;
  logic          i_pslverr;

  int n_total;
  int n_fail;

  apb_master #(.DW(DW), .AW(AW), .TIMEOUT(4)) u_dut (
    .pclk          (pclk),
    .preset        (preset),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_write   (i_cmd_write),
    .i_cmd_addr    (i_cmd_addr),
    .i_cmd_wdata   (i_cmd_wdata),
    .i_cmd_strb    (i_cmd_strb),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_rdata   (o_rsp_rdata),
    .o_rsp_err     (o_rsp_err),
    .o_rsp_timeout (o_rsp_timeout),
    .o_paddr       (o_paddr),
    .o_pwrite      (o_pwrite),
    .o_psel        (o_psel),
    .o_penable     (o_penable),
    .o_pwdata      (o_pwdata),
    .o_pstrb       (o_pstrb),
    .i_prdata      (i_prdata),
    .i_pready      (i_pready),
    .i_pslverr     (i_pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command for one edge (DUT must be in IDLE with ready high).
  task automatic issue(input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [SW-1:0] sb);
    i_cmd_valid = 1'b1;
    i_cmd_write = wr;
    i_cmd_addr  = a;
    i_cmd_wdata = wd;
    i_cmd_strb  = sb;
    step();
    i_cmd_valid = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_fail  = 0;
    preset      = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_write = 1'b0;
    i_cmd_addr  = '0;
    i_cmd_wdata = '0;
    i_cmd_strb  = '0;
    i_rsp_ready = 1'b1;
    i_prdata    = '0;
    i_pready    = 1'b1;
    i_pslverr   = 1'b0;

    // Reset state
    step(); step();
    chk("rst_cmd_ready", 64'(o_cmd_ready), 64'd0);
    chk("rst_psel",      64'(o_psel),      64'd0);
    chk("rst_penable",   64'(o_penable),   64'd0);
    chk("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(o_rsp_rdata), 64'd0);
    chk("rst_paddr",     64'(o_paddr),     64'd0);
    preset = 1'b0;
    step();
    chk("rst_ready_rise", 64'(o_cmd_ready), 64'd1);

    // Write 0x00 = 0xA5A55A5A, zero-wait slave
    issue(1'b1, 5'h00, 32'hA5A5_5A5A, 4'hF);
    chk("wr_setup_psel",    64'(o_psel),    64'd1);
    chk("wr_setup_penable", 64'(o_penable), 64'd0);
    chk("wr_setup_ready",   64'(o_cmd_ready), 64'd0);
    chk("wr_pwrite",        64'(o_pwrite),  64'd1);
    chk("wr_pstrb",         64'(o_pstrb),   64'hF);
    step();
    chk("wr_access_penable", 64'(o_penable), 64'd1);
    chk("wr_access_pwdata",  64'(o_pwdata),  64'hA5A5_5A5A);
    chk("wr_access_paddr",   64'(o_paddr),   64'h00);
    step();
    chk("wr_rsp_valid", 64'(o_rsp_valid), 64'd1);
    chk("wr_rsp_err",   64'(o_rsp_err),   64'd0);
    chk("wr_rsp_rdata", 64'(o_rsp_rdata), 64'd0);
    chk("wr_rsp_psel",  64'(o_psel),      64'd0);
    step();
    chk("wr_idle_ready", 64'(o_cmd_ready), 64'd1);
    chk("wr_idle_valid", 64'(o_rsp_valid), 64'd0);

    // Read 0x0C, one-wait slave returning 0xDEADBEEF
    i_prdata = 32'hDEAD_BEEF;
    i_pready = 1'b0;
    issue(1'b0, 5'h0C, 32'h1234_5678, 4'hF);
    chk("rd_pstrb",  64'(o_pstrb),  64'h0);
    chk("rd_pwrite", 64'(o_pwrite), 64'd0);
    step();
    chk("rd_access1", 64'(o_penable), 64'd1);
    step();
    chk("rd_access2_penable", 64'(o_penable),   64'd1);
    chk("rd_access2_valid",   64'(o_rsp_valid), 64'd0);
    i_pready = 1'b1;
    step();
    chk("rd_rsp_valid", 64'(o_rsp_valid), 64'd1);
    chk("rd_rsp_rdata", 64'(o_rsp_rdata), 64'hDEAD_BEEF);
    chk("rd_rsp_err",   64'(o_rsp_err),   64'd0);
    step();

    // Write to read-only register: pslverr with pready
    i_pslverr = 1'b1;
    issue(1'b1, 5'h0C, 32'h0000_0001, 4'hF);
    step();
    step();
    chk("slverr_err",     64'(o_rsp_err),     64'd1);
    chk("slverr_timeout", 64'(o_rsp_timeout), 64'd0);
    chk("slverr_rdata",   64'(o_rsp_rdata),   64'd0);
    i_pslverr = 1'b0;
    step();
    chk("slverr_next_ready", 64'(o_cmd_ready), 64'd1);

    // Timeout: pready stuck low -> exactly 4 ACCESS cycles
    i_pready = 1'b0;
    i_prdata = 32'hFFFF_0000;
    issue(1'b0, 5'h04, 32'h0, 4'h0);
    step();
    chk("to_access1", 64'(o_penable), 64'd1);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk("to_access_n", 64'({o_psel, o_penable, o_rsp_valid}), 64'b110);
    end
    step();
    chk("to_rsp_valid",   64'(o_rsp_valid),   64'd1);
    chk("to_rsp_err",     64'(o_rsp_err),     64'd1);
    chk("to_rsp_timeout", 64'(o_rsp_timeout), 64'd1);
    chk("to_rsp_rdata",   64'(o_rsp_rdata),   64'd0);
    chk("to_rsp_psel",    64'(o_psel),        64'd0);
    step();

    // pready rises in the 4th ACCESS cycle: normal completion wins
    i_prdata = 32'h0BAD_F00D;
    issue(1'b0, 5'h04, 32'h0, 4'h0);
    step(); step(); step(); step();
    chk("race_access4", 64'(o_penable), 64'd1);
    i_pready = 1'b1;
    step();
    chk("race_rsp_valid",   64'(o_rsp_valid),   64'd1);
    chk("race_rsp_timeout", 64'(o_rsp_timeout), 64'd0);
    chk("race_rsp_err",     64'(o_rsp_err),     64'd0);
    chk("race_rsp_rdata",   64'(o_rsp_rdata),   64'h0BAD_F00D);
    step();

    // Response backpressure: fields stable for 5 cycles
    i_rsp_ready = 1'b0;
    i_prdata    = 32'h1122_3344;
    issue(1'b0, 5'h10, 32'h0, 4'h0);
    step();
    step();
    i_prdata = 32'h5555_AAAA;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(o_rsp_valid), 64'd1);
      chk("bp_rdata", 64'(o_rsp_rdata), 64'h1122_3344);
      chk("bp_flags", 64'({o_rsp_err, o_rsp_timeout, o_cmd_ready, o_psel}), 64'b0000);
      step();
    end
    i_rsp_ready = 1'b1;
    step();
    chk("bp_release_valid", 64'(o_rsp_valid), 64'd0);
    chk("bp_release_ready", 64'(o_cmd_ready), 64'd1);

    // Reset during ACCESS of a read
    i_pready = 1'b0;
    i_prdata = 32'h7777_7777;
    issue(1'b0, 5'h08, 32'h0, 4'h0);
    step();
    chk("mid_access", 64'(o_penable), 64'd1);
    preset = 1'b1;
    step();
    chk("mid_rst_strobes", 64'({o_psel, o_penable, o_rsp_valid, o_cmd_ready}), 64'b0000);
    chk("mid_rst_fields",  64'({o_rsp_err, o_rsp_timeout, o_pwrite}), 64'b000);
    chk("mid_rst_paddr",   64'(o_paddr),     64'd0);
    chk("mid_rst_rdata",   64'(o_rsp_rdata), 64'd0);
    preset   = 1'b0;
    i_pready = 1'b1;
    step();
    chk("mid_post_valid", 64'(o_rsp_valid), 64'd0);
    chk("mid_post_ready", 64'(o_cmd_ready), 64'd1);
    i_prdata = 32'hCAFE_F00D;
    issue(1'b0, 5'h08, 32'h0, 4'h0);
    chk("re_rd_paddr", 64'(o_paddr), 64'h08);
    step();
    step();
    chk("re_rd_valid", 64'(o_rsp_valid), 64'd1);
    chk("re_rd_rdata", 64'(o_rsp_rdata), 64'hCAFE_F00D);
    chk("re_rd_err",   64'(o_rsp_err),   64'd0);
    step();

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
